// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default line timing.
package uart_pkg;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RECV  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Default system clock and line rate used when a parent does not override them.
    localparam int UART_DEFAULT_CLK_HZ   = 50_000_000;
    localparam int UART_DEFAULT_BIT_RATE = 9600;

endpackage : uart_pkg

// File: rtl/uart_rx.sv
// UART receiver: oversamples the RX pin with the system clock, samples each bit at
// its centre, and emits every received byte with a one-cycle valid strobe. An
// all-zero frame with a low stop bit is reported as BREAK instead of data.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = UART_DEFAULT_CLK_HZ,
    parameter int BIT_RATE     = UART_DEFAULT_BIT_RATE,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);

    // Only the first stop bit is examined; any further stop bits are idle-high
    // time absorbed by IDLE. A frame format without a stop bit has nothing to check.
    localparam bit CHECK_STOP = (STOP_BITS != 0);

    logic                    r_rxd_meta;
    logic                    r_rxd_sync;
    uart_state_t             r_state;
    uart_state_t             w_state_next;
    logic [CNT_W-1:0]        r_cycle_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_valid;
    logic                    r_break;
    logic                    r_armed;

    logic w_half_tick;
    logic w_bit_tick;
    logic w_stop_good;
    logic w_cnt_clear;
    logic w_shift_en;
    logic w_frame_ok;
    logic w_frame_break;
    logic w_stop_low;

    // Bring the asynchronous pin into the clock domain; idle-high reset level
    // keeps reset release from looking like a start bit.
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    assign w_half_tick = (r_cycle_cnt == HALF_LAST);
    assign w_bit_tick  = (r_cycle_cnt == FULL_LAST);
    assign w_stop_good = r_rxd_sync | ~CHECK_STOP;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: disabling the receiver abandons any frame in progress.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (!uart_rx_en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (!r_rxd_sync && r_armed) w_state_next = ST_START;
                ST_START: if (w_half_tick) w_state_next = r_rxd_sync ? ST_IDLE : ST_RECV;
                ST_RECV:  if (w_bit_tick && (r_bit_cnt == BIT_LAST)) w_state_next = ST_STOP;
                ST_STOP:  if (w_bit_tick) w_state_next = ST_IDLE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output/control decode: counter restarts, bit-centre shifts and stop-bit verdict.
    always_comb begin
        w_cnt_clear   = 1'b1;
        w_shift_en    = 1'b0;
        w_frame_ok    = 1'b0;
        w_frame_break = 1'b0;
        w_stop_low    = 1'b0;
        if (uart_rx_en) begin
            case (r_state)
                ST_START: w_cnt_clear = w_half_tick;
                ST_RECV: begin
                    w_cnt_clear = w_bit_tick;
                    w_shift_en  = w_bit_tick;
                end
                ST_STOP: begin
                    w_cnt_clear = w_bit_tick;
                    if (w_bit_tick) begin
                        if (w_stop_good) begin
                            w_frame_ok = 1'b1;
                        end else begin
                            w_stop_low    = 1'b1;
                            w_frame_break = (r_shift == '0);
                        end
                    end
                end
                default: w_cnt_clear = 1'b1;
            endcase
        end
    end

    // Cycle counter: measures half a bit in START and a whole bit in RECV/STOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (w_cnt_clear) begin
            r_cycle_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    // Payload bit counter and LSB-first shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_shift   <= {r_rxd_sync, r_shift[PAYLOAD_BITS-1:1]};
        end else if (r_state != ST_RECV) begin
            r_bit_cnt <= '0;
        end
    end

    // After a low stop bit (break or framing error) the line must return high
    // before another start bit is accepted, so a held-low line is one event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b1;
        end else if (w_stop_low) begin
            r_armed <= 1'b0;
        end else if (r_rxd_sync) begin
            r_armed <= 1'b1;
        end
    end

    // Registered strobes and held data; data only changes on a good frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_break <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= w_frame_ok;
            r_break <= w_frame_break;
            if (w_frame_ok) begin
                r_data <= r_shift;
            end
        end
    end

    assign uart_rx_valid = r_valid;
    assign uart_rx_break = r_break;
    assign uart_rx_data  = r_data;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx, run at 16 clocks per bit to keep frames short.
module tb_uart_rx;

    localparam int CLK_HZ   = 50_000_000;
    localparam int BIT_RATE = 3_125_000;
    localparam int CPB      = CLK_HZ / BIT_RATE;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    always #10 clk = ~clk;

    uart_rx #(
        .CLK_HZ       (CLK_HZ),
        .BIT_RATE     (BIT_RATE),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_break (uart_rx_break),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor, sampled on the falling edge away from DUT updates.
    int n_valid = 0;
    int n_break = 0;
    int n_both  = 0;
    int n_wide  = 0;
    initial begin
        logic prev_v;
        logic prev_b;
        prev_v = 1'b0;
        prev_b = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_rx_valid === 1'b1) n_valid++;
            if (uart_rx_break === 1'b1) n_break++;
            if (uart_rx_valid === 1'b1 && uart_rx_break === 1'b1) n_both++;
            if ((uart_rx_valid === 1'b1 && prev_v) || (uart_rx_break === 1'b1 && prev_b)) n_wide++;
            prev_v = (uart_rx_valid === 1'b1);
            prev_b = (uart_rx_break === 1'b1);
        end
    end

    // Watchdog: all stimulus is fixed-length, so this only fires on a bench hang.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a frame yields data iff its stop bit is high; an all-zero
    // payload with a low stop bit is a break; anything else is discarded.
    function automatic void model_frame(input logic [7:0] b, input bit stop,
                                        output bit ev, output bit eb);
        ev = stop;
        eb = !stop && (b == 8'h00);
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic apply_and_check(input string tag, input logic [7:0] b, input bit stop,
                                   input bit ev, input bit eb, input logic [7:0] ed,
                                   input int gap);
        int v0;
        int b0;
        v0 = n_valid;
        b0 = n_break;
        send_frame(b, stop);
        repeat (gap) @(negedge clk);
        check({tag, " valid count"}, 32'(n_valid - v0), 32'(ev));
        check({tag, " break count"}, 32'(n_break - b0), 32'(eb));
        check({tag, " data"}, 32'(uart_rx_data), 32'(ed));
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         exp_valid;
        bit         exp_break;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int         v0;
        int         b0;
        logic [7:0] model_data;
        logic [7:0] rb;
        bit         rs;
        bit         ev;
        bit         eb;

        vecs[0]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[1]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[2]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        vecs[3]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[4]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[5]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[6]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[7]  = '{8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA};
        vecs[8]  = '{8'h55, 1'b1, 1'b1, 1'b0, 8'h55};
        vecs[9]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h55};
        vecs[10] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
        vecs[12] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'h5A};

        // Reset and first byte.
        reset      = 1'b1;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        repeat (24) @(negedge clk);
        check("reset valid", 32'(uart_rx_valid), 32'd0);
        check("reset break", 32'(uart_rx_break), 32'd0);
        check("reset data", 32'(uart_rx_data), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        apply_and_check("first 0xAA", 8'hAA, 1'b1, 1'b1, 1'b0, 8'hAA, 50);

        // Table: back-to-back bytes, framing errors and a short break frame.
        for (int i = 0; i < 13; i++) begin
            apply_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop,
                            vecs[i].exp_valid, vecs[i].exp_break, vecs[i].exp_data, 50);
        end

        // Short low glitch on an idle line is rejected at the start-bit check.
        v0 = n_valid;
        b0 = n_break;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch valid count", 32'(n_valid - v0), 32'd0);
        check("glitch break count", 32'(n_break - b0), 32'd0);
        apply_and_check("after glitch 0x33", 8'h33, 1'b1, 1'b1, 1'b0, 8'h33, 20);

        // Line held low well past a frame: exactly one break, data retained.
        v0 = n_valid;
        b0 = n_break;
        uart_rxd = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("long break valid count", 32'(n_valid - v0), 32'd0);
        check("long break break count", 32'(n_break - b0), 32'd1);
        check("long break data held", 32'(uart_rx_data), 32'h33);
        apply_and_check("after break 0x96", 8'h96, 1'b1, 1'b1, 1'b0, 8'h96, 20);

        // Receiver disabled mid-frame: partial frame dropped silently.
        v0 = n_valid;
        b0 = n_break;
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) uart_rx_en = 1'b0;
            rb = 8'hC3;
            uart_rxd = rb[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        uart_rx_en = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("disable valid count", 32'(n_valid - v0), 32'd0);
        check("disable break count", 32'(n_break - b0), 32'd0);
        check("disable data held", 32'(uart_rx_data), 32'h96);
        apply_and_check("after disable 0x42", 8'h42, 1'b1, 1'b1, 1'b0, 8'h42, 20);

        // Reset mid-frame, then a clean frame.
        uart_rxd = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
        check("midreset valid", 32'(uart_rx_valid), 32'd0);
        check("midreset break", 32'(uart_rx_break), 32'd0);
        check("midreset data", 32'(uart_rx_data), 32'd0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        apply_and_check("after reset 0x81", 8'h81, 1'b1, 1'b1, 1'b0, 8'h81, 20);

        // Randomized frames against the reference model.
        model_data = 8'h81;
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 8'h00;
            rs = ($urandom_range(0, 3) != 0);
            model_frame(rb, rs, ev, eb);
            if (ev) model_data = rb;
            apply_and_check($sformatf("rand%0d", i), rb, rs, ev, eb, model_data,
                            rs ? int'($urandom_range(0, 6)) : int'($urandom_range(4, 10)));
        end

        check("valid and break exclusive", 32'(n_both), 32'd0);
        check("strobes one cycle wide", 32'(n_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx
